// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the MIPS-31 multi-cycle sequencer.
//   S_IDLE..S_HALT   3-bit state encodings visible on the debug state port
//   TIMEOUT_DEFAULT  default handshake wait limit in cycles
//   seq_state_e      typed FSM state built on those encodings
package cpu_seq_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_IF   = 3'd1;
  localparam logic [2:0] S_ID   = 3'd2;
  localparam logic [2:0] S_EX   = 3'd3;
  localparam logic [2:0] S_MEM  = 3'd4;
  localparam logic [2:0] S_WB   = 3'd5;
  localparam logic [2:0] S_HALT = 3'd6;

  localparam int unsigned TIMEOUT_DEFAULT = 200;

  typedef enum logic [2:0] {
    StIdle = S_IDLE,
    StIf   = S_IF,
    StId   = S_ID,
    StEx   = S_EX,
    StMem  = S_MEM,
    StWb   = S_WB,
    StHalt = S_HALT
  } seq_state_e;

endpackage

// File: rtl/seq_wait_timer.sv
// Handshake wait counter for the cycle sequencer.
//   clk, rst_n  clock and synchronous active-low reset
//   clr         force the count to zero (takes priority over inc)
//   inc         count one more wait cycle
//   expired     count has reached TIMEOUT-1
module seq_wait_timer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT,
  parameter int unsigned TIMEOUT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [TIMEOUT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr) begin
      cnt_q <= '0;
    end else if (inc) begin
      cnt_q <= cnt_q + TIMEOUT_W'(1);
    end
  end

  assign expired = (cnt_q == TIMEOUT_W'(TIMEOUT - 1));

endmodule

// File: rtl/cpu_cycle_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB sequencer for the MIPS-31 CPU.
//   clk, rst_n       clock and synchronous active-low reset
//   run              keep issuing instructions; 0 parks in IDLE after the current one
//   imem_ready       IMEM handshake completion (looked at only in IF)
//   dmem_ready       DMEM handshake completion (looked at only in MEM)
//   is_lw/is_sw/is_jump/is_branch/reg_W_dec  decoder outputs, held stable from ID to commit
//   imem_req, ir_we  fetch request and instruction-register latch strobe
//   dmem_req, dmem_we data access request and write qualifier
//   reg_we, pc_we    once-per-instruction commit strobes
//   state            current FSM state (debug)
//   retired          committed instruction count (wraps)
//   timeout_err      sticky flag, set when a handshake wait times out
module cpu_cycle_sequencer
  import cpu_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT   = TIMEOUT_DEFAULT,
  parameter int unsigned TIMEOUT_W = 8,
  parameter int unsigned RETIRE_W  = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic                imem_ready,
  input  logic                dmem_ready,
  input  logic                is_lw,
  input  logic                is_sw,
  input  logic                is_jump,
  input  logic                is_branch,
  input  logic                reg_W_dec,
  output logic                imem_req,
  output logic                ir_we,
  output logic                dmem_req,
  output logic                dmem_we,
  output logic                reg_we,
  output logic                pc_we,
  output logic [2:0]          state,
  output logic [RETIRE_W-1:0] retired,
  output logic                timeout_err
);

  seq_state_e          state_q, state_d;
  logic [RETIRE_W-1:0] retired_q;
  logic                timeout_err_q;

  logic commit;
  logic wait_inc, wait_expired;
  logic imem_req_c, ir_we_c, dmem_req_c, dmem_we_c, reg_we_c, pc_we_c;

  // Only a stalled handshake advances the timer; any other cycle restarts it,
  // so the count is always zero on entry to IF or MEM.
  assign wait_inc = ((state_q == StIf)  && !imem_ready) ||
                    ((state_q == StMem) && !dmem_ready);

  seq_wait_timer #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (TIMEOUT_W)
  ) u_wait_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (!wait_inc),
    .inc     (wait_inc),
    .expired (wait_expired)
  );

  always_comb begin
    state_d    = state_q;
    commit     = 1'b0;
    imem_req_c = 1'b0;
    ir_we_c    = 1'b0;
    dmem_req_c = 1'b0;
    dmem_we_c  = 1'b0;
    reg_we_c   = 1'b0;
    pc_we_c    = 1'b0;
    case (state_q)
      StIdle: begin
        if (run) state_d = StIf;
      end
      StIf: begin
        imem_req_c = 1'b1;
        // A ready arriving on the last allowed cycle still wins over the timeout.
        if (imem_ready) begin
          ir_we_c = 1'b1;
          state_d = StId;
        end else if (wait_expired) begin
          state_d = StHalt;
        end
      end
      StId: begin
        state_d = StEx;
      end
      StEx: begin
        if (is_lw || is_sw) begin
          state_d = StMem;
        end else if (is_jump || is_branch) begin
          commit   = 1'b1;
          pc_we_c  = 1'b1;
          reg_we_c = reg_W_dec;  // jal links here
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        dmem_req_c = 1'b1;
        dmem_we_c  = is_sw;
        if (dmem_ready) begin
          if (is_sw) begin
            commit  = 1'b1;
            pc_we_c = 1'b1;
          end else begin
            state_d = StWb;
          end
        end else if (wait_expired) begin
          state_d = StHalt;
        end
      end
      StWb: begin
        commit   = 1'b1;
        pc_we_c  = 1'b1;
        reg_we_c = reg_W_dec;
      end
      StHalt: begin
        state_d = StHalt;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
    if (commit) state_d = run ? StIf : StIdle;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      retired_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (commit) retired_q <= retired_q + RETIRE_W'(1);
      if (state_d == StHalt) timeout_err_q <= 1'b1;
    end
  end

  // Reset aborts the in-flight instruction, so no request or strobe may leak
  // out of the reset cycle even though the state register still holds it.
  assign imem_req    = imem_req_c & rst_n;
  assign ir_we       = ir_we_c    & rst_n;
  assign dmem_req    = dmem_req_c & rst_n;
  assign dmem_we     = dmem_we_c  & rst_n;
  assign reg_we      = reg_we_c   & rst_n;
  assign pc_we       = pc_we_c    & rst_n;
  assign state       = state_q;
  assign retired     = retired_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_cpu_cycle_sequencer.sv
module tb_cpu_cycle_sequencer;

  localparam int unsigned TIMEOUT  = 4;
  localparam int unsigned RETIRE_W = 32;

  // Strobe field bits: {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, timeout_err}
  localparam logic [6:0] NONE = 7'h00;
  localparam logic [6:0] IMR  = 7'h40;
  localparam logic [6:0] IRW  = 7'h20;
  localparam logic [6:0] DR   = 7'h10;
  localparam logic [6:0] DW   = 7'h08;
  localparam logic [6:0] RW   = 7'h04;
  localparam logic [6:0] PW   = 7'h02;
  localparam logic [6:0] TE   = 7'h01;

  typedef struct packed {
    logic [2:0]          st;
    logic [6:0]          strobes;
    logic [RETIRE_W-1:0] ret;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n, run, imem_ready, dmem_ready;
  logic is_lw, is_sw, is_jump, is_branch, reg_W_dec;
  logic imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, timeout_err;
  logic [2:0] state;
  logic [RETIRE_W-1:0] retired;

  int checks = 0;
  int failures = 0;
  obs_t  sb_q[$];
  string tag_q[$];

  always #5 clk = ~clk;

  cpu_cycle_sequencer #(
    .TIMEOUT   (TIMEOUT),
    .TIMEOUT_W (3),
    .RETIRE_W  (RETIRE_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .imem_ready  (imem_ready),
    .dmem_ready  (dmem_ready),
    .is_lw       (is_lw),
    .is_sw       (is_sw),
    .is_jump     (is_jump),
    .is_branch   (is_branch),
    .reg_W_dec   (reg_W_dec),
    .imem_req    (imem_req),
    .ir_we       (ir_we),
    .dmem_req    (dmem_req),
    .dmem_we     (dmem_we),
    .reg_we      (reg_we),
    .pc_we       (pc_we),
    .state       (state),
    .retired     (retired),
    .timeout_err (timeout_err)
  );

  task automatic set_dec(input logic lw, input logic sw, input logic j, input logic b,
                         input logic w);
    is_lw = lw; is_sw = sw; is_jump = j; is_branch = b; reg_W_dec = w;
  endtask

  // Push the expectation for the current cycle, compare at the falling edge,
  // then move to just after the next rising edge for the following step.
  task automatic chk(input logic [2:0] st, input logic [6:0] strobes,
                     input logic [RETIRE_W-1:0] ret, input string tag);
    obs_t e, o;
    string t;
    e.st = st; e.strobes = strobes; e.ret = ret;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
    o.st = state;
    o.strobes = {imem_req, ir_we, dmem_req, dmem_we, reg_we, pc_we, timeout_err};
    o.ret = retired;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed st=%0d strobes=%b ret=%0d expected st=%0d strobes=%b ret=%0d",
             t, o.st, o.strobes, o.ret, e.st, e.strobes, e.ret);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b1; imem_ready = 1'b1; dmem_ready = 1'b0;
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Reset held over two rising edges with run high
    @(posedge clk);
    #1;
    chk(3'd0, NONE, 0, "reset_hold");
    rst_n = 1'b1;
    chk(3'd0, NONE, 0, "reset_idle");

    // ALU instruction, zero-wait fetch
    chk(3'd1, IMR | IRW, 0, "alu_if");
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk(3'd2, NONE, 0, "alu_id");
    chk(3'd3, NONE, 0, "alu_ex");
    chk(3'd5, RW | PW, 0, "alu_wb");

    // lw with three DMEM wait cycles
    set_dec(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk(3'd1, IMR | IRW, 1, "lw_if");
    chk(3'd2, NONE, 1, "lw_id");
    chk(3'd3, NONE, 1, "lw_ex");
    dmem_ready = 1'b0;
    repeat (3) chk(3'd4, DR, 1, "lw_mem_wait");
    dmem_ready = 1'b1;
    chk(3'd4, DR, 1, "lw_mem_ready");
    dmem_ready = 1'b0;
    chk(3'd5, RW | PW, 1, "lw_wb");

    // sw (reg_W_dec high must not leak into reg_we) then jal back-to-back
    set_dec(1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    chk(3'd1, IMR | IRW, 2, "sw_if");
    chk(3'd2, NONE, 2, "sw_id");
    chk(3'd3, NONE, 2, "sw_ex");
    dmem_ready = 1'b1;
    chk(3'd4, DR | DW | PW, 2, "sw_mem");
    dmem_ready = 1'b0;
    set_dec(1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk(3'd1, IMR | IRW, 3, "jal_if");
    chk(3'd2, NONE, 3, "jal_id");
    chk(3'd3, RW | PW, 3, "jal_ex");

    // Fetch timeout: four stalled IF cycles, then HALT is sticky
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    imem_ready = 1'b0;
    repeat (TIMEOUT) chk(3'd1, IMR, 4, "to_if_wait");
    for (int i = 0; i < 10; i++) begin
      imem_ready = 1'($urandom_range(1));
      dmem_ready = 1'($urandom_range(1));
      chk(3'd6, TE, 4, "halt_hold");
    end

    // Only reset leaves HALT
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1; imem_ready = 1'b0; dmem_ready = 1'b0;
    chk(3'd0, NONE, 0, "halt_reset");

    // Retry: ready on the last allowed cycle wins
    repeat (TIMEOUT - 1) chk(3'd1, IMR, 0, "retry_wait");
    imem_ready = 1'b1;
    chk(3'd1, IMR | IRW, 0, "retry_ready");
    set_dec(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    run = 1'b0;
    chk(3'd2, NONE, 0, "drop_id");
    chk(3'd3, NONE, 0, "drop_ex");
    chk(3'd5, RW | PW, 0, "drop_wb");
    chk(3'd0, NONE, 1, "drop_idle");
    chk(3'd0, NONE, 1, "drop_stay");

    // Reset landing in MEM aborts with no write strobes
    run = 1'b1;
    set_dec(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk(3'd0, NONE, 1, "abort_idle");
    chk(3'd1, IMR | IRW, 1, "abort_if");
    chk(3'd2, NONE, 1, "abort_id");
    chk(3'd3, NONE, 1, "abort_ex");
    dmem_ready = 1'b1;
    rst_n = 1'b0;
    chk(3'd4, NONE, 1, "abort_mem_rst");
    rst_n = 1'b1; run = 1'b0; dmem_ready = 1'b0;
    chk(3'd0, NONE, 0, "abort_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
